// File: rtl/connect_queue.sv
// connect_queue: first-word-fall-through elastic FIFO that registers the data path and cuts valid/ready chains
module connect_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0] RECEIVE_DATA,
  output logic                  RECEIVE_READY,
  output logic                  SEND_VALID,
  output logic [DATA_WIDTH-1:0] SEND_DATA,
  input  logic                  SEND_READY,
  output logic [ADDR_WIDTH:0]   COUNT
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;
  assign RECEIVE_READY = count_q != FULL;
  assign SEND_VALID    = count_q != '0;
  assign SEND_DATA     = mem_q[rd_ptr_q];
  assign COUNT         = count_q;
  always_comb begin
    push     = RECEIVE_VALID & RECEIVE_READY;
    pop      = SEND_VALID & SEND_READY;
    wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = (push & ~pop) ? count_q + (ADDR_WIDTH + 1)'(1) :
               (pop & ~push) ? count_q - (ADDR_WIDTH + 1)'(1) : count_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wr_ptr_q] <= RECEIVE_DATA;
  end
endmodule

// File: tb/tb_connect_queue.sv
// tb_connect_queue: randomized and directed checks of connect_queue against a queue-based reference model
module tb_connect_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0;
  logic [31:0] rdata = '0;
  logic        rr;
  logic        sv;
  logic [31:0] sdata;
  logic        sr = 1'b0;
  logic [2:0]  cnt;
  logic [31:0] q[$];
  int          checks = 0;
  int          failures = 0;
  int          npops = 0;

  connect_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
    .CLK(clk), .RST(rst), .RECEIVE_VALID(rv), .RECEIVE_DATA(rdata), .RECEIVE_READY(rr),
    .SEND_VALID(sv), .SEND_DATA(sdata), .SEND_READY(sr), .COUNT(cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic s);
    bit do_push, do_pop;
    rst = r; rv = v; rdata = d; sr = s;
    do_pop  = (q.size() != 0) && s;
    do_push = v && (q.size() != 4);
    if (sv && s && !r) npops++;
    @(posedge clk);
    #1;
    if (r) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 1);
    step(0, 0, 0, 0);
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    checks++; if (sv !== 1'b0) begin failures++; $display("FAIL reset_send_valid got=%b exp=0", sv); end
    checks++; if (rr !== 1'b1) begin failures++; $display("FAIL reset_receive_ready got=%b exp=1", rr); end
  endtask

  task automatic test_single();
    step(0, 1, 32'hA5A5_0001, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (sv !== 1'b1) begin failures++; $display("FAIL single_valid cyc=%0d got=%b exp=1", i, sv); end
      checks++; if (sdata !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data cyc=%0d got=%h exp=a5a50001", i, sdata); end
      checks++; if (cnt !== 3'd1) begin failures++; $display("FAIL single_count cyc=%0d got=%0d exp=1", i, cnt); end
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 1);
    checks++; if (sv !== 1'b0 || cnt !== 3'd0) begin failures++; $display("FAIL single_pop got valid=%b count=%0d exp valid=0 count=0", sv, cnt); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) step(0, 1, 32'(i), 0);
    checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", cnt); end
    checks++; if (rr !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", rr); end
    step(0, 1, 32'd5, 0);
    step(0, 1, 32'd5, 0);
    checks++; if (cnt !== 3'd4 || sdata !== 32'd1) begin failures++; $display("FAIL fill_reject got count=%0d head=%0d exp count=4 head=1", cnt, sdata); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (sv !== 1'b1 || sdata !== 32'(i)) begin failures++; $display("FAIL fill_drain_data got valid=%b data=%0d exp valid=1 data=%0d", sv, sdata, i); end
      step(0, 0, 0, 1);
      if (i == 1) begin
        checks++; if (rr !== 1'b1) begin failures++; $display("FAIL fill_ready_after_pop got=%b exp=1", rr); end
      end
    end
    checks++; if (cnt !== 3'd0 || sv !== 1'b0) begin failures++; $display("FAIL fill_empty got count=%0d valid=%b exp count=0 valid=0", cnt, sv); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 32'(i), 1);
      checks++; if (sv !== 1'b1 || sdata !== 32'(i) || cnt !== 3'd1) begin
        failures++; $display("FAIL stream i=%0d got valid=%b data=%0d count=%0d exp valid=1 data=%0d count=1", i, sv, sdata, cnt, i);
      end
    end
    step(0, 0, 0, 1);
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL stream_drain got=%0d exp=0", cnt); end
  endtask

  task automatic test_random();
    int start_pops;
    start_pops = npops;
    for (int i = 0; i < 240; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
      checks++; if (cnt !== 3'(q.size()) || sv !== (q.size() != 0) || rr !== (q.size() != 4)) begin
        failures++; $display("FAIL random_state i=%0d got count=%0d valid=%b ready=%b exp count=%0d", i, cnt, sv, rr, q.size());
      end
      if (q.size() != 0) begin
        checks++; if (sdata !== q[0]) begin failures++; $display("FAIL random_data i=%0d got=%h exp=%h", i, sdata, q[0]); end
      end
    end
    checks++; if (npops - start_pops < 40) begin failures++; $display("FAIL random_wraps got pops=%0d exp>=40", npops - start_pops); end
    while (q.size() != 0) begin
      checks++; if (sdata !== q[0]) begin failures++; $display("FAIL random_drain got=%h exp=%h", sdata, q[0]); end
      step(0, 0, 0, 1);
    end
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL random_empty got=%0d exp=0", cnt); end
  endtask

  task automatic test_full_pop();
    for (int i = 10; i <= 13; i++) step(0, 1, 32'(i), 0);
    step(0, 1, 32'd14, 1);
    checks++; if (cnt !== 3'd3 || sdata !== 32'd11) begin failures++; $display("FAIL full_pop got count=%0d head=%0d exp count=3 head=11", cnt, sdata); end
    checks++; if (rr !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", rr); end
    step(0, 1, 32'd14, 0);
    checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL full_pop_refill got=%0d exp=4", cnt); end
    for (int i = 11; i <= 14; i++) begin
      checks++; if (sdata !== 32'(i)) begin failures++; $display("FAIL full_pop_order got=%0d exp=%0d", sdata, i); end
      step(0, 0, 0, 1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 1, 32'hBAD0_0000 + 32'(i), 0);
    checks++; if (cnt !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", cnt); end
    step(1, 1, 32'hDEAD_BEEF, 1);
    checks++; if (cnt !== 3'd0 || sv !== 1'b0 || rr !== 1'b1) begin
      failures++; $display("FAIL mid_reset got count=%0d valid=%b ready=%b exp 0/0/1", cnt, sv, rr);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      checks++; if (sv !== 1'b0) begin failures++; $display("FAIL mid_stale_valid cyc=%0d got=%b exp=0", i, sv); end
    end
    step(0, 1, 32'h600D_0001, 0);
    checks++; if (sv !== 1'b1 || sdata !== 32'h600D_0001 || cnt !== 3'd1) begin
      failures++; $display("FAIL mid_fresh got valid=%b data=%h count=%0d exp 1/600d0001/1", sv, sdata, cnt);
    end
    step(0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
